// File: rtl/bp_fe_bht_ctrl.sv
// bp_fe_bht_ctrl: 1RW BHT SRAM controller. It runs the post-reset init sweep, serves lookups, and applies
// queued direction updates as read-modify-write. Optional perf counters: define BP_FE_BHT_CTRL_PERF_EN.
module bp_fe_bht_ctrl #(
    parameter int bht_idx_width_p   = 9,
    parameter int bp_cnt_sat_bits_p = 2,
    parameter int upd_fifo_els_p    = 4,
    parameter int max_stall_p       = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_n_i,
    input  logic                         r_v_i,
    input  logic [bht_idx_width_p-1:0]   idx_r_i,
    output logic                         r_ready_o,
    output logic                         predict_v_o,
    output logic                         predict_o,
    input  logic                         w_v_i,
    input  logic [bht_idx_width_p-1:0]   idx_w_i,
    input  logic                         taken_i,
    output logic                         w_ready_o,
    output logic                         mem_v_o,
    output logic                         mem_w_o,
    output logic [bht_idx_width_p-1:0]   mem_addr_o,
    output logic [bp_cnt_sat_bits_p-1:0] mem_data_o,
    input  logic [bp_cnt_sat_bits_p-1:0] mem_data_i,
    output logic                         init_done_o
`ifdef BP_FE_BHT_CTRL_PERF_EN
    ,
    output logic [31:0]                  perf_lookups_o,
    output logic [31:0]                  perf_updates_o,
    output logic [31:0]                  perf_stalls_o
`endif
);

    localparam int ptr_w_lp   = $clog2(upd_fifo_els_p);
    localparam int stall_w_lp = $clog2(max_stall_p + 1);
    localparam int ent_w_lp   = bht_idx_width_p + 1;

    localparam logic [bp_cnt_sat_bits_p-1:0] cnt_max_lp  = {bp_cnt_sat_bits_p{1'b1}};
    localparam logic [bp_cnt_sat_bits_p-1:0] cnt_zero_lp = {bp_cnt_sat_bits_p{1'b0}};
    localparam logic [bp_cnt_sat_bits_p-1:0] cnt_one_lp  = {{(bp_cnt_sat_bits_p-1){1'b0}}, 1'b1};
    localparam logic [bp_cnt_sat_bits_p-1:0] init_val_lp = {1'b0, {(bp_cnt_sat_bits_p-1){1'b1}}};
    localparam logic [bht_idx_width_p-1:0]   idx_last_lp = {bht_idx_width_p{1'b1}};
    localparam logic [bht_idx_width_p-1:0]   idx_zero_lp = {bht_idx_width_p{1'b0}};
    localparam logic [bht_idx_width_p-1:0]   idx_one_lp  = {{(bht_idx_width_p-1){1'b0}}, 1'b1};
    localparam logic [ptr_w_lp:0]            ptr_one_lp  = (ptr_w_lp + 1)'(32'd1);
    localparam logic [stall_w_lp-1:0]        stall_one_lp = stall_w_lp'(32'd1);
    localparam logic [stall_w_lp-1:0]        stall_max_lp = stall_w_lp'(max_stall_p);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_UPD_RD = 2'd2,
        S_UPD_WR = 2'd3
    } state_e;

    // Saturating step of a direction counter toward the resolved outcome.
    function automatic logic [bp_cnt_sat_bits_p-1:0] sat_next(
        input logic [bp_cnt_sat_bits_p-1:0] cnt,
        input logic                         taken
    );
        logic [bp_cnt_sat_bits_p-1:0] res;
        if (taken && (cnt != cnt_max_lp)) begin
            res = cnt + cnt_one_lp;
        end else if (!taken && (cnt != cnt_zero_lp)) begin
            res = cnt - cnt_one_lp;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    state_e                         state_q, state_d;
    logic [bht_idx_width_p-1:0]     init_addr_q, init_addr_d;
    logic                           init_done_q, init_done_d;
    logic [stall_w_lp-1:0]          stall_cnt_q, stall_cnt_d;
    logic [bht_idx_width_p-1:0]     rmw_idx_q, rmw_idx_d;
    logic                           rmw_taken_q, rmw_taken_d;
    logic [bp_cnt_sat_bits_p-1:0]   nxt_cnt_q, nxt_cnt_d;
    logic                           predict_v_q, predict_v_d;
    logic                           predict_last_q;
    logic [ent_w_lp-1:0]            fifo_q [upd_fifo_els_p];
    logic [ptr_w_lp:0]              wr_ptr_q, rd_ptr_q;

    logic                           fifo_empty_s, fifo_full_s;
    logic                           enq_s, deq_s;
    logic [ent_w_lp-1:0]            head_s;
    logic                           r_ready_s;
    logic                           mem_v_s, mem_w_s;
    logic [bht_idx_width_p-1:0]     mem_addr_s;
    logic [bp_cnt_sat_bits_p-1:0]   mem_data_s;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_s  = (wr_ptr_q[ptr_w_lp] != rd_ptr_q[ptr_w_lp]) &&
                          (wr_ptr_q[ptr_w_lp-1:0] == rd_ptr_q[ptr_w_lp-1:0]);
    assign head_s       = fifo_q[rd_ptr_q[ptr_w_lp-1:0]];
    assign w_ready_o    = init_done_q & ~fifo_full_s;
    assign enq_s        = w_v_i & w_ready_o;

    // Next-state, port arbitration and SRAM command generation.
    always_comb begin
        state_d     = state_q;
        init_addr_d = init_addr_q;
        init_done_d = init_done_q;
        stall_cnt_d = stall_cnt_q;
        rmw_idx_d   = rmw_idx_q;
        rmw_taken_d = rmw_taken_q;
        nxt_cnt_d   = nxt_cnt_q;
        predict_v_d = 1'b0;
        deq_s       = 1'b0;
        r_ready_s   = 1'b0;
        mem_v_s     = 1'b0;
        mem_w_s     = 1'b0;
        mem_addr_s  = idx_zero_lp;
        mem_data_s  = cnt_zero_lp;
        case (state_q)
            S_INIT: begin
                mem_v_s    = 1'b1;
                mem_w_s    = 1'b1;
                mem_addr_s = init_addr_q;
                mem_data_s = init_val_lp;
                if (init_addr_q == idx_last_lp) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                    init_addr_d = idx_zero_lp;
                end else begin
                    init_addr_d = init_addr_q + idx_one_lp;
                end
            end
            S_IDLE: begin
                r_ready_s = ~(~fifo_empty_s && (stall_cnt_q == stall_max_lp));
                if (r_v_i && r_ready_s) begin
                    mem_v_s     = 1'b1;
                    mem_addr_s  = idx_r_i;
                    predict_v_d = 1'b1;
                    if (!fifo_empty_s) begin
                        stall_cnt_d = stall_cnt_q + stall_one_lp;
                    end else begin
                        stall_cnt_d = stall_cnt_q;
                    end
                end else if (!fifo_empty_s) begin
                    mem_v_s     = 1'b1;
                    mem_addr_s  = head_s[ent_w_lp-1:1];
                    deq_s       = 1'b1;
                    rmw_idx_d   = head_s[ent_w_lp-1:1];
                    rmw_taken_d = head_s[0];
                    stall_cnt_d = {stall_w_lp{1'b0}};
                    state_d     = S_UPD_RD;
                end else begin
                    stall_cnt_d = {stall_w_lp{1'b0}};
                end
            end
            S_UPD_RD: begin
                nxt_cnt_d = sat_next(mem_data_i, rmw_taken_q);
                state_d   = S_UPD_WR;
            end
            S_UPD_WR: begin
                mem_v_s    = 1'b1;
                mem_w_s    = 1'b1;
                mem_addr_s = rmw_idx_q;
                mem_data_s = nxt_cnt_q;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // Controller state, update FIFO and prediction registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= S_INIT;
            init_addr_q    <= idx_zero_lp;
            init_done_q    <= 1'b0;
            stall_cnt_q    <= {stall_w_lp{1'b0}};
            rmw_idx_q      <= idx_zero_lp;
            rmw_taken_q    <= 1'b0;
            nxt_cnt_q      <= cnt_zero_lp;
            predict_v_q    <= 1'b0;
            predict_last_q <= 1'b0;
            fifo_q         <= '{default: {ent_w_lp{1'b0}}};
            wr_ptr_q       <= {(ptr_w_lp + 1){1'b0}};
            rd_ptr_q       <= {(ptr_w_lp + 1){1'b0}};
        end else begin
            state_q     <= state_d;
            init_addr_q <= init_addr_d;
            init_done_q <= init_done_d;
            stall_cnt_q <= stall_cnt_d;
            rmw_idx_q   <= rmw_idx_d;
            rmw_taken_q <= rmw_taken_d;
            nxt_cnt_q   <= nxt_cnt_d;
            predict_v_q <= predict_v_d;
            if (predict_v_q) begin
                predict_last_q <= mem_data_i[bp_cnt_sat_bits_p-1];
            end
            if (enq_s) begin
                fifo_q[wr_ptr_q[ptr_w_lp-1:0]] <= {idx_w_i, taken_i};
                wr_ptr_q <= wr_ptr_q + ptr_one_lp;
            end
            if (deq_s) begin
                rd_ptr_q <= rd_ptr_q + ptr_one_lp;
            end
        end
    end

    // SRAM strobes are held low while reset is asserted, even though the FSM sits in INIT.
    assign mem_v_o     = mem_v_s & reset_n_i;
    assign mem_w_o     = mem_w_s & reset_n_i;
    assign mem_addr_o  = mem_addr_s;
    assign mem_data_o  = (mem_w_s & reset_n_i) ? mem_data_s : cnt_zero_lp;
    assign r_ready_o   = r_ready_s;
    assign init_done_o = init_done_q;
    assign predict_v_o = predict_v_q;
    assign predict_o   = predict_v_q ? mem_data_i[bp_cnt_sat_bits_p-1] : predict_last_q;

`ifdef BP_FE_BHT_CTRL_PERF_EN
    logic [31:0] perf_lookups_q, perf_updates_q, perf_stalls_q;
    logic        lookup_acc_s;

    assign lookup_acc_s = r_v_i & r_ready_s;

    // Free-running wrapping event counters.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            perf_lookups_q <= 32'd0;
            perf_updates_q <= 32'd0;
            perf_stalls_q  <= 32'd0;
        end else begin
            if (lookup_acc_s) begin
                perf_lookups_q <= perf_lookups_q + 32'd1;
            end
            if (state_q == S_UPD_WR) begin
                perf_updates_q <= perf_updates_q + 32'd1;
            end
            if (r_v_i && !r_ready_s && init_done_q) begin
                perf_stalls_q <= perf_stalls_q + 32'd1;
            end
        end
    end

    assign perf_lookups_o = perf_lookups_q;
    assign perf_updates_o = perf_updates_q;
    assign perf_stalls_o  = perf_stalls_q;
`endif

endmodule
